// File: rtl/mest_pro_seq_engine_if.sv
// Instruction-memory bus between the MESTPro sequencing engine (master) and its program store (slave).
interface mest_pro_seq_engine_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              imem_rd;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W+3:0] imem_data;

  modport master (output imem_rd, output imem_addr, input  imem_data);
  modport slave  (input  imem_rd, input  imem_addr, output imem_data);
endinterface

// File: rtl/mest_pro_seq_engine.sv
// MESTPro datapath: owns pc/accumulator, fetches, decodes and executes one op per EXECUTE strobe.
// Define MEST_PRO_SEQ_CHECK_EN to add the sticky strobe-sequence checker output o_seq_err.
module mest_pro_seq_engine #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int LAST_ADDR = 2**ADDR_W - 1
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_idle,
  input  logic                  i_fetch,
  input  logic                  i_decode,
  input  logic                  i_execute,
  mest_pro_seq_engine_if.master imem,
  output logic                  o_exec_done,
  output logic                  o_end_of_code,
  output logic [DATA_W-1:0]     o_acc,
  output logic [DATA_W-1:0]     o_out_data,
  output logic                  o_out_valid
`ifdef MEST_PRO_SEQ_CHECK_EN
  ,
  output logic                  o_seq_err
`endif
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADDI = 4'h2,
    OP_SUBI = 4'h3,
    OP_ANDI = 4'h4,
    OP_XORI = 4'h5,
    OP_JMP  = 4'h6,
    OP_JZ   = 4'h7,
    OP_OUT  = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W+3:0] ir_q, ir_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              carry_q, carry_d;

  logic              idle_s, exec_s, dec_s, fetch_s, exec_en;
  logic [3:0]        op;
  logic [DATA_W-1:0] imm;
  logic [DATA_W:0]   sum;
  logic              jump_taken, end_of_code;

  // Reset masks every strobe; otherwise one phase wins: idle > execute > decode > fetch.
  always_comb begin
    idle_s  = i_idle & ~i_reset;
    exec_s  = i_execute & ~i_idle & ~i_reset;
    dec_s   = i_decode & ~i_execute & ~i_idle & ~i_reset;
    fetch_s = i_fetch & ~i_decode & ~i_execute & ~i_idle & ~i_reset;
  end

`ifdef MEST_PRO_SEQ_CHECK_EN
  typedef enum logic [2:0] {PH_NONE, PH_IDLE, PH_FETCH, PH_DECODE, PH_EXEC} phase_e;

  phase_e phase_q, phase_d;
  logic   seq_err_q, seq_err_d;
  logic   multi_s, dec_bad, exec_bad;

  // A misordered or overlapping execute is dropped entirely so it cannot corrupt state.
  always_comb begin
    multi_s   = ~i_reset && ($countones({i_idle, i_fetch, i_decode, i_execute}) > 1);
    dec_bad   = i_decode & ~i_reset & (phase_q != PH_FETCH);
    exec_bad  = i_execute & ~i_reset & (phase_q != PH_DECODE);
    exec_en   = exec_s & ~multi_s & ~exec_bad;
    seq_err_d = seq_err_q | multi_s | dec_bad | exec_bad;
    if (idle_s)       phase_d = PH_IDLE;
    else if (exec_s)  phase_d = PH_EXEC;
    else if (dec_s)   phase_d = PH_DECODE;
    else if (fetch_s) phase_d = PH_FETCH;
    else              phase_d = PH_NONE;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      phase_q   <= PH_NONE;
      seq_err_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign o_seq_err = seq_err_q;
`else
  always_comb exec_en = exec_s;
`endif

  always_comb begin
    op          = ir_q[DATA_W+3:DATA_W];
    imm         = ir_q[DATA_W-1:0];
    sum         = '0;
    jump_taken  = 1'b0;
    end_of_code = 1'b0;
    pc_d        = pc_q;
    acc_d       = acc_q;
    ir_d        = ir_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    carry_d     = carry_q;
    if (idle_s) begin
      pc_d = '0;
    end else if (exec_en) begin
      // JZ tests the accumulator as it was before this execute.
      jump_taken  = (op == OP_JMP) || ((op == OP_JZ) && (acc_q == '0));
      end_of_code = (op == OP_HALT) || ((pc_q == LAST_PC) && !jump_taken);
      case (op)
        OP_LDI:  acc_d = imm;
        OP_ADDI: begin
          sum     = {1'b0, acc_q} + {1'b0, imm};
          acc_d   = sum[DATA_W-1:0];
          carry_d = sum[DATA_W];
        end
        OP_SUBI: begin
          sum     = {1'b0, acc_q} - {1'b0, imm};
          acc_d   = sum[DATA_W-1:0];
          carry_d = sum[DATA_W];
        end
        OP_ANDI: acc_d = acc_q & imm;
        OP_XORI: acc_d = acc_q ^ imm;
        OP_OUT: begin
          out_data_d  = acc_q;
          out_valid_d = 1'b1;
        end
        default: ;
      endcase
      if (jump_taken)       pc_d = imm[ADDR_W-1:0];
      else if (end_of_code) pc_d = '0;
      else                  pc_d = pc_q + 1'b1;
    end else if (dec_s) begin
      ir_d = imem.imem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      pc_q        <= '0;
      acc_q       <= '0;
      ir_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      ir_q        <= ir_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      carry_q     <= carry_d;
    end
  end

  assign imem.imem_rd   = fetch_s;
  assign imem.imem_addr = pc_q;
  assign o_exec_done    = exec_en;
  assign o_end_of_code  = end_of_code;
  assign o_acc          = acc_q;
  assign o_out_data     = out_data_q;
  assign o_out_valid    = out_valid_q;

endmodule

// File: tb/tb_mest_pro_seq_engine.sv
// Self-checking bench for mest_pro_seq_engine: directed scenarios plus random programs vs a program-level model.
// Builds with or without MEST_PRO_SEQ_CHECK_EN; the sequence-checker scenario only exists when it is defined.
module tb_mest_pro_seq_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_reset, i_idle, i_fetch, i_decode, i_execute;
  logic       o_exec_done, o_end_of_code, o_out_valid;
  logic [7:0] o_acc, o_out_data;
`ifdef MEST_PRO_SEQ_CHECK_EN
  logic       o_seq_err;
`endif

  mest_pro_seq_engine_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mest_pro_seq_engine #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_idle       (i_idle),
    .i_fetch      (i_fetch),
    .i_decode     (i_decode),
    .i_execute    (i_execute),
    .imem         (bus),
    .o_exec_done  (o_exec_done),
    .o_end_of_code(o_end_of_code),
    .o_acc        (o_acc),
    .o_out_data   (o_out_data),
    .o_out_valid  (o_out_valid)
`ifdef MEST_PRO_SEQ_CHECK_EN
    ,
    .o_seq_err    (o_seq_err)
`endif
  );

  // Program store: read data appears the cycle after a read request.
  logic [11:0] mem [0:255];
  always @(posedge clk) if (bus.imem_rd) bus.imem_data <= mem[bus.imem_addr];

  int total = 0;
  int bad   = 0;
  int out_pulses = 0;
  always @(negedge clk) if (o_out_valid === 1'b1) out_pulses++;

  // Program-level model state
  int m_pc, m_acc, m_ir, m_bus, m_out_data;
  bit m_out_valid;
`ifdef MEST_PRO_SEQ_CHECK_EN
  int m_prev;
  bit m_err;
`endif

  // Expectations for the cycle just driven (registered outputs reflect earlier cycles)
  logic       e_rd, e_done, e_eoc, e_out_valid;
  logic [7:0] e_addr, e_acc, e_out_data;

  // Captures from the last run_instr
  logic       f_rd_act, f_ov_act, f_rd_exp, f_ov_exp, x_done_act, x_eoc_act, x_done_exp, x_eoc_exp;
  logic [7:0] f_addr_act, f_acc_act, f_od_act, f_addr_exp, f_acc_exp, f_od_exp;

  // Drives one cycle of strobes at the falling edge and advances the model by that cycle.
  task automatic phase(input bit f, input bit d, input bit e, input bit idl, input bit rst);
    int op, imm;
    bit jump, ef, ed, ee, ei, exec_ok;
`ifdef MEST_PRO_SEQ_CHECK_EN
    bit multi, dbad, ebad;
`endif
    @(negedge clk);
    i_fetch = f; i_decode = d; i_execute = e; i_idle = idl; i_reset = rst;
    e_acc = 8'(m_acc); e_out_data = 8'(m_out_data); e_out_valid = m_out_valid; e_addr = 8'(m_pc);
    ei = idl && !rst;
    ee = e && !idl && !rst;
    ed = d && !e && !idl && !rst;
    ef = f && !d && !e && !idl && !rst;
    exec_ok = ee;
`ifdef MEST_PRO_SEQ_CHECK_EN
    multi = !rst && ((int'(f) + int'(d) + int'(e) + int'(idl)) > 1);
    dbad  = d && !rst && (m_prev != 1);
    ebad  = e && !rst && (m_prev != 2);
    if (multi || ebad) exec_ok = 0;
    m_err  = m_err | multi | dbad | ebad;
    m_prev = ei ? 4 : ee ? 3 : ed ? 2 : ef ? 1 : 0;
    if (rst) begin m_err = 0; m_prev = 0; end
`endif
    e_rd = ef; e_done = exec_ok; e_eoc = 0; m_out_valid = 0;
    op  = m_ir / 256;
    imm = m_ir % 256;
    if (rst) begin
      m_pc = 0; m_acc = 0; m_ir = 0; m_out_data = 0;
    end else if (ei) begin
      m_pc = 0;
    end else if (exec_ok) begin
      jump  = (op == 6) || (op == 7 && m_acc == 0);
      e_eoc = (op == 15) || (m_pc == 255 && !jump);
      case (op)
        1: m_acc = imm;
        2: m_acc = (m_acc + imm) % 256;
        3: m_acc = (m_acc - imm + 256) % 256;
        4: m_acc = m_acc & imm;
        5: m_acc = m_acc ^ imm;
        8: begin m_out_data = m_acc; m_out_valid = 1; end
        default: ;
      endcase
      m_pc = jump ? imm : (e_eoc ? 0 : (m_pc + 1) % 256);
    end else if (ed) begin
      m_ir = m_bus;
    end
    if (ef) m_bus = int'(mem[m_pc]);
    #1;
  endtask

  task automatic run_instr();
    phase(1, 0, 0, 0, 0);
    f_addr_act = bus.imem_addr; f_rd_act = bus.imem_rd; f_acc_act = o_acc;
    f_ov_act = o_out_valid; f_od_act = o_out_data;
    f_addr_exp = e_addr; f_rd_exp = e_rd; f_acc_exp = e_acc; f_ov_exp = e_out_valid; f_od_exp = e_out_data;
    phase(0, 1, 0, 0, 0);
    phase(0, 0, 1, 0, 0);
    x_done_act = o_exec_done; x_eoc_act = o_end_of_code;
    x_done_exp = e_done;      x_eoc_exp = e_eoc;
  endtask

  task automatic test_reset();
    phase(0, 0, 0, 0, 1);
    phase(0, 0, 0, 0, 0);
    total++; if (o_acc !== 8'h00) begin bad++; $display("[TB] FAIL reset_acc: got %0h expected 0", o_acc); end
    total++; if (o_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", o_out_valid); end
    total++; if (o_out_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_data: got %0h expected 0", o_out_data); end
    total++; if (bus.imem_addr !== 8'h00) begin bad++; $display("[TB] FAIL reset_pc: got %0h expected 0", bus.imem_addr); end
    total++; if ({bus.imem_rd, o_exec_done, o_end_of_code} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_strobe_outs: got %b expected 000", {bus.imem_rd, o_exec_done, o_end_of_code});
    end
  endtask

  task automatic test_program();
    int p0;
    phase(0, 0, 0, 0, 1);
    mem[0] = 12'h105; mem[1] = 12'h203; mem[2] = 12'h800; mem[3] = 12'hF00;
    p0 = out_pulses;
    for (int k = 0; k < 4; k++) begin
      run_instr();
      total++; if (f_addr_act !== 8'(k)) begin bad++; $display("[TB] FAIL prog_fetch_addr%0d: got %0h expected %0h", k, f_addr_act, k); end
      total++; if (x_done_act !== 1'b1) begin bad++; $display("[TB] FAIL prog_exec_done%0d: got %0b expected 1", k, x_done_act); end
      total++; if (x_eoc_act !== logic'(k == 3)) begin bad++; $display("[TB] FAIL prog_eoc%0d: got %0b expected %0b", k, x_eoc_act, k == 3); end
    end
    total++; if (f_ov_act !== 1'b1 || f_od_act !== 8'd8) begin
      bad++; $display("[TB] FAIL prog_out: got valid=%0b data=%0d expected valid=1 data=8", f_ov_act, f_od_act);
    end
    phase(0, 0, 0, 0, 0);
    total++; if (bus.imem_addr !== 8'h00) begin bad++; $display("[TB] FAIL prog_pc_after_halt: got %0h expected 0", bus.imem_addr); end
    total++; if (out_pulses - p0 !== 1) begin bad++; $display("[TB] FAIL prog_pulse_count: got %0d expected 1", out_pulses - p0); end
  endtask

  task automatic test_wrap_and_jz();
    phase(0, 0, 0, 0, 1);
    mem[0] = 12'h1FF; mem[1] = 12'h201; mem[2] = 12'h710; mem[8'h10] = 12'h6FE;
    run_instr(); run_instr(); run_instr();
    total++; if (f_acc_act !== 8'h00) begin bad++; $display("[TB] FAIL addi_wrap_acc: got %0h expected 0", f_acc_act); end
    run_instr();
    total++; if (f_addr_act !== 8'h10) begin bad++; $display("[TB] FAIL jz_target_fetch: got %0h expected 10", f_addr_act); end
  endtask

  task automatic test_end_of_code();
    mem[8'hFE] = 12'h000; mem[8'hFF] = 12'h000;
    run_instr();
    total++; if (x_eoc_act !== 1'b0) begin bad++; $display("[TB] FAIL eoc_early: got %0b expected 0", x_eoc_act); end
    run_instr();
    total++; if (f_addr_act !== 8'hFF || x_eoc_act !== 1'b1) begin
      bad++; $display("[TB] FAIL eoc_last_addr: got addr=%0h eoc=%0b expected addr=ff eoc=1", f_addr_act, x_eoc_act);
    end
    run_instr();
    total++; if (f_addr_act !== 8'h00) begin bad++; $display("[TB] FAIL eoc_restart_addr: got %0h expected 0", f_addr_act); end
  endtask

  task automatic test_reset_mid();
    phase(0, 0, 0, 0, 1);
    mem[0] = 12'h1AA; mem[1] = 12'h109;
    run_instr();
    phase(1, 0, 0, 0, 0);
    phase(0, 1, 0, 0, 1);
    phase(0, 0, 1, 0, 0);
    total++; if (o_acc !== 8'h00 || bus.imem_addr !== 8'h00) begin
      bad++; $display("[TB] FAIL reset_mid_state: got acc=%0h pc=%0h expected acc=0 pc=0", o_acc, bus.imem_addr);
    end
    total++; if (o_exec_done !== e_done) begin bad++; $display("[TB] FAIL reset_mid_done: got %0b expected %0b", o_exec_done, e_done); end
    phase(0, 0, 0, 0, 0);
    total++; if (o_acc !== 8'h00 || o_out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_mid_no_effect: got acc=%0h valid=%0b expected acc=0 valid=0", o_acc, o_out_valid);
    end
  endtask

  task automatic test_unknown_op();
    phase(0, 0, 0, 0, 1);
    mem[0] = 12'h133; mem[1] = 12'h000; mem[2] = 12'hB55; mem[3] = 12'h000;
    run_instr(); run_instr(); run_instr();
    total++; if (x_done_act !== 1'b1) begin bad++; $display("[TB] FAIL opB_done: got %0b expected 1", x_done_act); end
    run_instr();
    total++; if (f_addr_act !== 8'h03 || f_acc_act !== 8'h33) begin
      bad++; $display("[TB] FAIL opB_nop: got pc=%0h acc=%0h expected pc=3 acc=33", f_addr_act, f_acc_act);
    end
  endtask

  task automatic test_priority();
    phase(0, 0, 0, 0, 1);
    mem[0] = 12'h1C3; mem[1] = 12'h2FF;
    run_instr();
    phase(1, 0, 0, 0, 0);
    phase(0, 1, 0, 0, 0);
    phase(0, 0, 1, 1, 0);
    total++; if (o_exec_done !== 1'b0) begin bad++; $display("[TB] FAIL prio_idle_exec_done: got %0b expected 0", o_exec_done); end
    phase(1, 1, 0, 0, 0);
    total++; if (bus.imem_addr !== 8'h00 || o_acc !== 8'hC3) begin
      bad++; $display("[TB] FAIL prio_idle_state: got pc=%0h acc=%0h expected pc=0 acc=c3", bus.imem_addr, o_acc);
    end
    total++; if (bus.imem_rd !== 1'b0) begin bad++; $display("[TB] FAIL prio_decode_over_fetch: got rd=%0b expected 0", bus.imem_rd); end
  endtask

  task automatic test_random();
    phase(0, 0, 0, 0, 1);
    for (int a = 0; a < 256; a++) mem[a] = {4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) == 0) phase(0, 0, 0, 1, 0);
      run_instr();
      total++; if (f_addr_act !== f_addr_exp || f_rd_act !== f_rd_exp) begin
        bad++; $display("[TB] FAIL rand_fetch%0d: got addr=%0h rd=%0b expected addr=%0h rd=%0b", n, f_addr_act, f_rd_act, f_addr_exp, f_rd_exp);
      end
      total++; if (f_acc_act !== f_acc_exp) begin bad++; $display("[TB] FAIL rand_acc%0d: got %0h expected %0h", n, f_acc_act, f_acc_exp); end
      total++; if (f_ov_act !== f_ov_exp || f_od_act !== f_od_exp) begin
        bad++; $display("[TB] FAIL rand_out%0d: got valid=%0b data=%0h expected valid=%0b data=%0h", n, f_ov_act, f_od_act, f_ov_exp, f_od_exp);
      end
      total++; if (x_done_act !== x_done_exp || x_eoc_act !== x_eoc_exp) begin
        bad++; $display("[TB] FAIL rand_exec%0d: got done=%0b eoc=%0b expected done=%0b eoc=%0b", n, x_done_act, x_eoc_act, x_done_exp, x_eoc_exp);
      end
    end
  endtask

`ifdef MEST_PRO_SEQ_CHECK_EN
  task automatic test_seq_err();
    phase(0, 0, 0, 0, 1);
    mem[0] = 12'h1AA; mem[1] = 12'h201;
    run_instr();
    phase(0, 0, 1, 0, 0);
    total++; if (o_exec_done !== 1'b0) begin bad++; $display("[TB] FAIL seq_exec_suppressed: got %0b expected 0", o_exec_done); end
    phase(0, 0, 0, 0, 0);
    total++; if (o_seq_err !== 1'b1 || o_acc !== 8'hAA) begin
      bad++; $display("[TB] FAIL seq_err_set: got err=%0b acc=%0h expected err=1 acc=aa", o_seq_err, o_acc);
    end
    run_instr();
    phase(0, 0, 0, 0, 0);
    total++; if (o_seq_err !== 1'b1) begin bad++; $display("[TB] FAIL seq_err_sticky: got %0b expected 1", o_seq_err); end
    phase(0, 0, 0, 0, 1);
    phase(0, 0, 0, 0, 0);
    total++; if (o_seq_err !== 1'b0) begin bad++; $display("[TB] FAIL seq_err_cleared: got %0b expected 0", o_seq_err); end
  endtask
`endif

  initial begin
    i_reset = 1'b1; i_idle = 1'b0; i_fetch = 1'b0; i_decode = 1'b0; i_execute = 1'b0;
    m_pc = 0; m_acc = 0; m_ir = 0; m_bus = 0; m_out_data = 0; m_out_valid = 0;
`ifdef MEST_PRO_SEQ_CHECK_EN
    m_prev = 0; m_err = 0;
`endif
    for (int a = 0; a < 256; a++) mem[a] = 12'h000;
    test_reset();
    test_program();
    test_wrap_and_jz();
    test_end_of_code();
    test_reset_mid();
    test_unknown_op();
    test_priority();
`ifdef MEST_PRO_SEQ_CHECK_EN
    test_seq_err();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
